inta_sequencer: RTL and testbench

- CPU-side interrupt acknowledge sequencer of the 8259 PIC; it sits between the Priority_Resolver and the CPU bus.
- Consumes the resolver's chosen interrupt level and asserts INT when that level beats everything in service.
- Runs the two-pulse 8086-mode INTA sequence: owns the ISR register, drives the interrupt vector onto the data bus and returns the IRR clear pulse to the resolver.
- Handles normal and automatic EOI.

---
 rtl/pic_pkg.sv | 20 ++
 rtl/isr_prio_enc.sv | 22 ++
 rtl/inta_sequencer.sv | 139 +++++++++++++
 tb/tb_inta_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 PIC interrupt-acknowledge path.
package pic_pkg;

    localparam int unsigned NUM_IR       = 8;
    localparam logic [2:0]  SPURIOUS_LVL = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        WAIT2,
        ACK2,
        DONE
    } seq_state_e;

    function automatic logic [NUM_IR-1:0] lvl_mask(input logic [2:0] lvl);
        lvl_mask = {{(NUM_IR-1){1'b0}}, 1'b1} << lvl;
    endfunction

endpackage

// File: rtl/isr_prio_enc.sv
// Fixed-priority encoder over the in-service register: IR0 is highest priority.
module isr_prio_enc
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] req_i,
    output logic [2:0]        hi_o,
    output logic              none_o
);

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        hi_o   = 3'd0;
        none_o = 1'b1;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                hi_o   = 3'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode INTA sequencer: raises INT, owns the ISR, returns the IRR clear pulse
// and drives the interrupt vector during the second acknowledge pulse.
module inta_sequencer
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_pending,
    input  logic [2:0]        chosen_interrupt,
    input  logic              inta_n,
    input  logic              aeoi,
    input  logic [4:0]        vector_base,
    input  logic              eoi,
    input  logic              eoi_specific,
    input  logic [2:0]        eoi_level,
    output logic              int_out,
    output logic [NUM_IR-1:0] isr,
    output logic              clear,
    output logic [2:0]        clear_level,
    output logic [7:0]        data_out,
    output logic              data_oe
);

    seq_state_e state;
    logic       inta_q;
    logic [2:0] lvl;
    logic       spurious;

    logic [2:0] in_service_hi;
    logic       isr_none;

    logic              inta_fall;
    logic              inta_rise;
    logic              may_request;
    logic              ack_set;
    logic [NUM_IR-1:0] set_mask;
    logic [NUM_IR-1:0] eoi_mask;
    logic [NUM_IR-1:0] aeoi_mask;
    logic [NUM_IR-1:0] isr_next;

    isr_prio_enc u_isr_prio_enc (
        .req_i  (isr),
        .hi_o   (in_service_hi),
        .none_o (isr_none)
    );

    always_comb begin
        inta_fall   = !inta_n && inta_q;
        inta_rise   = inta_n && !inta_q;
        may_request = irq_pending && (isr_none || (chosen_interrupt < in_service_hi));
        ack_set     = (state == REQ) && inta_fall && irq_pending;

        set_mask  = ack_set ? lvl_mask(chosen_interrupt) : '0;
        aeoi_mask = '0;
        if ((state == ACK2) && inta_rise && aeoi && !spurious) begin
            aeoi_mask = lvl_mask(lvl);
        end

        eoi_mask = '0;
        if (eoi) begin
            if (eoi_specific) begin
                eoi_mask = lvl_mask(eoi_level);
            end else if (!isr_none) begin
                eoi_mask = lvl_mask(in_service_hi);
            end
        end

        // Applying the set after the clears lets an acknowledge beat a same-cycle EOI.
        isr_next = (isr & ~(eoi_mask | aeoi_mask)) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            inta_q      <= 1'b1;
            lvl         <= 3'd0;
            spurious    <= 1'b0;
            int_out     <= 1'b0;
            isr         <= '0;
            clear       <= 1'b0;
            clear_level <= 3'd0;
            data_out    <= 8'd0;
            data_oe     <= 1'b0;
        end else begin
            inta_q <= inta_n;
            clear  <= 1'b0;
            isr    <= isr_next;
            unique case (state)
                IDLE: begin
                    if (may_request) begin
                        state   <= REQ;
                        int_out <= 1'b1;
                    end
                end
                // INT cannot be retracted once raised; a vanished request turns spurious.
                REQ: begin
                    if (inta_fall) begin
                        state <= ACK1;
                        if (irq_pending) begin
                            lvl         <= chosen_interrupt;
                            spurious    <= 1'b0;
                            clear       <= 1'b1;
                            clear_level <= chosen_interrupt;
                        end else begin
                            lvl      <= SPURIOUS_LVL;
                            spurious <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (inta_rise) begin
                        state   <= WAIT2;
                        int_out <= 1'b0;
                    end
                end
                WAIT2: begin
                    if (inta_fall) begin
                        state    <= ACK2;
                        data_out <= {vector_base, lvl};
                        data_oe  <= 1'b1;
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        state   <= DONE;
                        data_oe <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Randomised, self-checking bench for inta_sequencer with a behavioural ISR model.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq_pending;
    logic [2:0] chosen_interrupt;
    logic       inta_n;
    logic       aeoi;
    logic [4:0] vector_base;
    logic       eoi;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] isr;
    logic       clear;
    logic [2:0] clear_level;
    logic [7:0] data_out;
    logic       data_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inta_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .irq_pending      (irq_pending),
        .chosen_interrupt (chosen_interrupt),
        .inta_n           (inta_n),
        .aeoi             (aeoi),
        .vector_base      (vector_base),
        .eoi              (eoi),
        .eoi_specific     (eoi_specific),
        .eoi_level        (eoi_level),
        .int_out          (int_out),
        .isr              (isr),
        .clear            (clear),
        .clear_level      (clear_level),
        .data_out         (data_out),
        .data_oe          (data_oe)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request allowed when nothing in service or the level beats the highest in service.
    function automatic bit beats(input logic [2:0] c, input logic [7:0] s);
        for (int i = 0; i < 8; i++) begin
            if (s[i]) return (int'(c) < i);
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] clear_lowest(input logic [7:0] s);
        logic [7:0] r = s;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                r[i] = 1'b0;
                return r;
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b0; irq_pending = 1'b0; chosen_interrupt = 3'd0; inta_n = 1'b1;
        aeoi = 1'b0; vector_base = 5'd0; eoi = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        step(); step();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", int_out); end
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL reset_isr got %h want 00", isr); end
        checks++; if (clear !== 1'b0 || clear_level !== 3'd0) begin errors++; $display("FAIL reset_clear got %b/%0d want 0/0", clear, clear_level); end
        checks++; if (data_out !== 8'h00 || data_oe !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%b want 00/0", data_out, data_oe); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        irq_pending = 1'b1; chosen_interrupt = 3'd3; vector_base = 5'h08;
        step();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL single_int got %b want 1", int_out); end
        inta_n = 1'b0; step();
        checks++; if (clear !== 1'b1 || clear_level !== 3'd3) begin errors++; $display("FAIL single_clear got %b/%0d want 1/3", clear, clear_level); end
        checks++; if (isr !== 8'h08) begin errors++; $display("FAIL single_isr got %h want 08", isr); end
        inta_n = 1'b1; step();
        checks++; if (clear !== 1'b0 || int_out !== 1'b0) begin errors++; $display("FAIL single_wait2 got clear %b int %b want 0 0", clear, int_out); end
        irq_pending = 1'b0; step();
        inta_n = 1'b0; step();
        checks++; if (data_oe !== 1'b1 || data_out !== 8'h43) begin errors++; $display("FAIL single_vec got %h/%b want 43/1", data_out, data_oe); end
        inta_n = 1'b1; step();
        checks++; if (data_oe !== 1'b0 || isr !== 8'h08) begin errors++; $display("FAIL single_end got oe %b isr %h want 0 08", data_oe, isr); end
        step();
    endtask

    task automatic test_nesting();
        irq_pending = 1'b1; chosen_interrupt = 3'd5;
        step(); step();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL nest_lower got %b want 0", int_out); end
        chosen_interrupt = 3'd1; step();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL nest_higher got %b want 1", int_out); end
        inta_n = 1'b0; step();
        checks++; if (isr !== 8'h0A || clear_level !== 3'd1) begin errors++; $display("FAIL nest_isr got %h/%0d want 0a/1", isr, clear_level); end
        inta_n = 1'b1; irq_pending = 1'b0; step();
        inta_n = 1'b0; step();
        checks++; if (data_out !== 8'h41) begin errors++; $display("FAIL nest_vec got %h want 41", data_out); end
        inta_n = 1'b1; step(); step();
        eoi = 1'b1; eoi_specific = 1'b0; step(); eoi = 1'b0;
        checks++; if (isr !== 8'h08) begin errors++; $display("FAIL nest_eoi got %h want 08", isr); end
        eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3; step(); eoi = 1'b0;
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL nest_seoi got %h want 00", isr); end
        eoi = 1'b1; eoi_specific = 1'b0; step(); eoi = 1'b0;
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL nest_eoi_empty got %h want 00", isr); end
    endtask

    task automatic test_aeoi();
        aeoi = 1'b1; irq_pending = 1'b1; chosen_interrupt = 3'd6; vector_base = 5'h1F;
        step();
        inta_n = 1'b0; step();
        checks++; if (isr !== 8'h40) begin errors++; $display("FAIL aeoi_set got %h want 40", isr); end
        inta_n = 1'b1; irq_pending = 1'b0; step();
        inta_n = 1'b0; step();
        checks++; if (data_out !== 8'hFE || data_oe !== 1'b1) begin errors++; $display("FAIL aeoi_vec got %h/%b want fe/1", data_out, data_oe); end
        inta_n = 1'b1; step();
        checks++; if (isr !== 8'h00 || data_oe !== 1'b0) begin errors++; $display("FAIL aeoi_clr got %h/%b want 00/0", isr, data_oe); end
        step();
        aeoi = 1'b0;
    endtask

    task automatic test_collision();
        irq_pending = 1'b1; chosen_interrupt = 3'd4; vector_base = 5'h02;
        step();
        inta_n = 1'b0; eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4; step();
        eoi = 1'b0;
        checks++; if (isr !== 8'h10 || clear !== 1'b1) begin errors++; $display("FAIL collide_isr got %h/%b want 10/1", isr, clear); end
        inta_n = 1'b1; irq_pending = 1'b0; step();
        inta_n = 1'b0; step();
        inta_n = 1'b1; step(); step();
        checks++; if (isr !== 8'h10) begin errors++; $display("FAIL collide_end got %h want 10", isr); end
    endtask

    task automatic test_spurious();
        irq_pending = 1'b1; chosen_interrupt = 3'd2; vector_base = 5'h15;
        step();
        irq_pending = 1'b0; step();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL spur_hold got %b want 1", int_out); end
        inta_n = 1'b0; step();
        checks++; if (clear !== 1'b0 || isr !== 8'h10) begin errors++; $display("FAIL spur_ack1 got %b/%h want 0/10", clear, isr); end
        inta_n = 1'b1; step();
        inta_n = 1'b0; step();
        checks++; if (data_out !== 8'hAF || data_oe !== 1'b1) begin errors++; $display("FAIL spur_vec got %h/%b want af/1", data_out, data_oe); end
        inta_n = 1'b1; step(); step();
        checks++; if (isr !== 8'h10) begin errors++; $display("FAIL spur_isr got %h want 10", isr); end
    endtask

    task automatic test_reset_mid();
        irq_pending = 1'b1; chosen_interrupt = 3'd0; vector_base = 5'h0A;
        step();
        inta_n = 1'b0; step();
        inta_n = 1'b1; irq_pending = 1'b0; step();
        inta_n = 1'b0; step();
        checks++; if (data_oe !== 1'b1 || isr !== 8'h11) begin errors++; $display("FAIL rmid_pre got %b/%h want 1/11", data_oe, isr); end
        reset = 1'b0; step();
        checks++; if (data_oe !== 1'b0 || isr !== 8'h00 || int_out !== 1'b0 || clear !== 1'b0 || data_out !== 8'h00)
            begin errors++; $display("FAIL rmid_reset got oe %b isr %h int %b clr %b dout %h want 0 00 0 0 00", data_oe, isr, int_out, clear, data_out); end
        reset = 1'b1; inta_n = 1'b1; step();
        inta_n = 1'b0; step();
        checks++; if (clear !== 1'b0 || data_oe !== 1'b0 || int_out !== 1'b0) begin errors++; $display("FAIL rmid_idle_fall got %b/%b/%b want 0/0/0", clear, data_oe, int_out); end
        inta_n = 1'b1; step();
        irq_pending = 1'b1; chosen_interrupt = 3'd5; step();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL rmid_rereq got %b want 1", int_out); end
    endtask

    task automatic test_random();
        logic [7:0] exp_isr;
        bit         exp_req;
        bit         spur;
        logic [2:0] c;
        logic [4:0] vb;
        logic       ae;
        reset = 1'b0; irq_pending = 1'b0; inta_n = 1'b1; eoi = 1'b0; step();
        reset = 1'b1; step();
        exp_isr = 8'h00;
        for (int it = 0; it < 80; it++) begin
            c = 3'($urandom_range(0, 7)); vb = 5'($urandom); ae = 1'($urandom);
            chosen_interrupt = c; vector_base = vb; aeoi = ae; irq_pending = 1'b1;
            step();
            exp_req = beats(c, exp_isr);
            checks++; if (int_out !== exp_req) begin errors++; $display("FAIL rnd_int it %0d got %b want %b", it, int_out, exp_req); end
            if (!exp_req) begin
                irq_pending = 1'b0; eoi = 1'b1; eoi_specific = 1'($urandom); eoi_level = 3'($urandom);
                step();
                eoi = 1'b0;
                exp_isr = eoi_specific ? (exp_isr & ~(8'h01 << eoi_level)) : clear_lowest(exp_isr);
                checks++; if (isr !== exp_isr) begin errors++; $display("FAIL rnd_eoi it %0d got %h want %h", it, isr, exp_isr); end
            end else begin
                spur = ($urandom_range(0, 3) == 0);
                if (spur) irq_pending = 1'b0;
                inta_n = 1'b0; step();
                if (!spur) exp_isr[c] = 1'b1;
                checks++; if (isr !== exp_isr || clear !== !spur || (!spur && clear_level !== c))
                    begin errors++; $display("FAIL rnd_ack1 it %0d got isr %h clr %b lvl %0d want %h %b %0d", it, isr, clear, clear_level, exp_isr, !spur, c); end
                inta_n = 1'b1; irq_pending = 1'b0; step();
                repeat ($urandom_range(0, 2)) step();
                inta_n = 1'b0; step();
                checks++; if (data_oe !== 1'b1 || data_out !== {vb, (spur ? 3'd7 : c)})
                    begin errors++; $display("FAIL rnd_vec it %0d got %h/%b want %h/1", it, data_out, data_oe, {vb, (spur ? 3'd7 : c)}); end
                inta_n = 1'b1; step();
                if (ae && !spur) exp_isr[c] = 1'b0;
                checks++; if (data_oe !== 1'b0 || isr !== exp_isr) begin errors++; $display("FAIL rnd_done it %0d got %b/%h want 0/%h", it, data_oe, isr, exp_isr); end
                step();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_nesting();
        test_aeoi();
        test_collision();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
